// File: rtl/mult_iter_p25519.sv
// Digit-serial 256x256 multiplier with valid/ready handshake, clock enable and
// canonical reduction of the product modulo p = 2^255 - 19.
module mult_iter_p25519 #(
  parameter int WIDTH   = 256,
  parameter int DIGIT_W = 32,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_full,
  output logic [254:0]         out_mod,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = $clog2(N);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int T1_W  = 263;
  localparam logic [WIDTH-1:0] P = (WIDTH'(1) << 255) - WIDTH'(19);

  if (WIDTH != 256 || (WIDTH % DIGIT_W) != 0) begin : g_bad_param
    $error("mult_iter_p25519: WIDTH must be 256 and divisible by DIGIT_W");
  end

  typedef enum logic [2:0] {IDLE, MULT, RED1, RED2, FINAL, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [TAG_W-1:0]     tag_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic [T1_W-1:0]      t1;
  logic [WIDTH-1:0]     t2;
  logic [SH_W-1:0]      shift_amt;
  logic [DIGIT_W-1:0]   digit;
  logic [2*WIDTH-1:0]   partial;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MULT;
      MULT:    if (cnt == CNT_W'(N - 1)) state_next = RED1;
      RED1:    state_next = RED2;
      RED2:    state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // One partial product per MULT cycle: A times the current digit of B, aligned.
  always_comb begin
    shift_amt = SH_W'(cnt) * SH_W'(DIGIT_W);
    digit     = b_reg[shift_amt +: DIGIT_W];
    partial   = ((2*WIDTH)'(a_reg) * (2*WIDTH)'(digit)) << shift_amt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      tag_reg  <= '0;
      acc      <= '0;
      cnt      <= '0;
      t1       <= '0;
      t2       <= '0;
      out_full <= '0;
      out_mod  <= '0;
      out_tag  <= '0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            tag_reg <= in_tag;
            acc     <= '0;
            cnt     <= '0;
          end
        end
        MULT: begin
          acc <= acc + partial;
          cnt <= cnt + CNT_W'(1);
        end
        // 2^255 == 19 (mod p), so the high part folds back in multiplied by 19.
        RED1: t1 <= T1_W'(acc[254:0]) + T1_W'(acc[2*WIDTH-1:255]) * T1_W'(19);
        RED2: t2 <= WIDTH'(t1[254:0]) + WIDTH'(t1[T1_W-1:255]) * WIDTH'(19);
        // t2 < 2p here, so one conditional subtraction yields the canonical value.
        FINAL: begin
          out_mod  <= (t2 >= P) ? 255'(t2 - P) : t2[254:0];
          out_full <= acc;
          out_tag  <= tag_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
